// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus and fetch-to-decode handoff between fetch_sequencer and its neighbours.
// The master side is the fetch sequencer; the slave side is memory plus decode.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic               ir_valid;
  logic               ir_ready;
  logic [INSTR_W-1:0] ir_data;
  logic [ADDR_W-1:0]  ir_pc;

  modport master (
    output imem_addr, imem_rd, ir_valid, ir_data, ir_pc,
    input  imem_data, ir_ready
  );

  modport slave (
    input  imem_addr, imem_rd, ir_valid, ir_data, ir_pc,
    output imem_data, ir_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction fetch controller: start/halt, branch redirect,
// fixed memory read latency and a valid/ready handoff of each instruction to decode.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       MEM_LAT  = 0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]        HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_sequencer_if.master bus,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalt} state_e;

  localparam logic [1:0]        LatMax = 2'(MEM_LAT);
  localparam logic [ADDR_W-1:0] PcOne  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [1:0]         lat_q, lat_d;
  logic [INSTR_W-1:0] ir_data_q, ir_data_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic [15:0]        retired_q, retired_d;
  logic               halt_op;

  assign halt_op = (ir_data_q[INSTR_W-1 -: 6] == HALT_OP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      lat_q     <= '0;
      ir_data_q <= '0;
      ir_pc_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      lat_q     <= lat_d;
      ir_data_q <= ir_data_d;
      ir_pc_q   <= ir_pc_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lat_d     = lat_q;
    ir_data_d = ir_data_q;
    ir_pc_d   = ir_pc_q;
    retired_d = retired_q;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (start) begin
          lat_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (redirect) begin
          pc_d  = redirect_pc;
          lat_d = '0;
        end else if (lat_q == LatMax) begin
          ir_data_d = bus.imem_data;
          ir_pc_d   = pc_q;
          pc_d      = pc_q + PcOne;
          state_d   = StHold;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StHold: begin
        // A transfer coinciding with a redirect still counts as accepted.
        if (bus.ir_ready && (retired_q != 16'hFFFF)) begin
          retired_d = retired_q + 16'd1;
        end
        if (redirect) begin
          pc_d    = redirect_pc;
          lat_d   = '0;
          state_d = StFetch;
        end else if (bus.ir_ready) begin
          if (halt_op) begin
            state_d = StHalt;
          end else begin
            lat_d   = '0;
            state_d = StFetch;
          end
        end
      end
      StHalt: begin
        if (start) begin
          lat_d   = '0;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.imem_addr = pc_q;
  assign bus.imem_rd   = (state_q == StFetch);
  assign bus.ir_valid  = (state_q == StHold);
  assign bus.ir_data   = ir_data_q;
  assign bus.ir_pc     = ir_pc_q;
  assign busy          = (state_q == StFetch) || (state_q == StHold);
  assign halted        = (state_q == StHalt);
  assign retired       = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench: a MEM_LAT=0 instance driven by a per-cycle vector table and a MEM_LAT=3
// instance exercised by hand-written redirect/wrap and asynchronous reset sequences.
module tb_fetch_sequencer;

  typedef struct {
    logic        st;
    logic        rd;
    logic [5:0]  rpc;
    logic        rdy;
    logic [5:0]  e_addr;
    logic        e_rd;
    logic        e_v;
    logic [5:0]  e_ipc;
    logic        e_busy;
    logic        e_halt;
    logic [15:0] e_ret;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        st0, rdr0, st3, rdr3;
  logic [5:0]  rpc0, rpc3;
  logic        busy0, halted0, busy3, halted3;
  logic [15:0] ret0, ret3;
  int          total;
  int          bad;
  vec_t        vecs[$];

  fetch_sequencer_if #(.ADDR_W(6), .INSTR_W(32)) b0 ();
  fetch_sequencer_if #(.ADDR_W(6), .INSTR_W(32)) b3 ();

  fetch_sequencer #(.MEM_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start(st0), .redirect(rdr0), .redirect_pc(rpc0),
    .bus(b0), .busy(busy0), .halted(halted0), .retired(ret0)
  );

  fetch_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(st3), .redirect(rdr3), .redirect_pc(rpc3),
    .bus(b3), .busy(busy3), .halted(halted3), .retired(ret3)
  );

  // Memory image: word k = k, except word 5 which is the halt instruction.
  function automatic logic [31:0] word(input logic [5:0] a);
    if (a == 6'd5) return {6'b111111, 26'h0};
    return {6'h00, 20'h0, a};
  endfunction

  assign b0.imem_data = word(b0.imem_addr);
  assign b3.imem_data = word(b3.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int st, input int rd, input int rpc, input int rdy,
                              input int addr, input int erd, input int ev, input int ipc,
                              input int eb, input int eh, input int ret);
    vec_t v;
    v.st = st[0]; v.rd = rd[0]; v.rpc = rpc[5:0]; v.rdy = rdy[0];
    v.e_addr = addr[5:0]; v.e_rd = erd[0]; v.e_v = ev[0]; v.e_ipc = ipc[5:0];
    v.e_busy = eb[0]; v.e_halt = eh[0]; v.e_ret = ret[15:0];
    return v;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " addr0"}, 32'(b0.imem_addr), 32'd0);
    chk({tag, " rd0"},   32'(b0.imem_rd),   32'd0);
    chk({tag, " v0"},    32'(b0.ir_valid),  32'd0);
    chk({tag, " data0"}, b0.ir_data,        32'd0);
    chk({tag, " ipc0"},  32'(b0.ir_pc),     32'd0);
    chk({tag, " busy0"}, 32'(busy0),        32'd0);
    chk({tag, " halt0"}, 32'(halted0),      32'd0);
    chk({tag, " ret0"},  32'(ret0),         32'd0);
    chk({tag, " addr3"}, 32'(b3.imem_addr), 32'd0);
    chk({tag, " rd3"},   32'(b3.imem_rd),   32'd0);
    chk({tag, " v3"},    32'(b3.ir_valid),  32'd0);
    chk({tag, " data3"}, b3.ir_data,        32'd0);
    chk({tag, " ipc3"},  32'(b3.ir_pc),     32'd0);
    chk({tag, " busy3"}, 32'(busy3),        32'd0);
    chk({tag, " ret3"},  32'(ret3),         32'd0);
  endtask

  initial begin
    logic [5:0] exp_pc [4];
    int         cnt;
    int         guard;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    st0 = 1'b0; rdr0 = 1'b0; rpc0 = '0; b0.ir_ready = 1'b0;
    st3 = 1'b0; rdr3 = 1'b0; rpc3 = '0; b3.ir_ready = 1'b1;

    // st rd rpc rdy | addr rd v ipc busy halt ret
    vecs.push_back(mk(1, 0,  0, 1,   0, 1, 0,  0, 1, 0,  0));
    vecs.push_back(mk(0, 0,  0, 1,   1, 0, 1,  0, 1, 0,  0));
    vecs.push_back(mk(0, 0,  0, 1,   1, 1, 0,  0, 1, 0,  1));
    vecs.push_back(mk(0, 0,  0, 1,   2, 0, 1,  1, 1, 0,  1));
    vecs.push_back(mk(0, 0,  0, 1,   2, 1, 0,  1, 1, 0,  2));
    vecs.push_back(mk(0, 0,  0, 1,   3, 0, 1,  2, 1, 0,  2));
    vecs.push_back(mk(0, 0,  0, 1,   3, 1, 0,  2, 1, 0,  3));
    vecs.push_back(mk(0, 0,  0, 1,   4, 0, 1,  3, 1, 0,  3));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 0, 4, 0, 1, 3, 1, 0, 3));
    vecs.push_back(mk(0, 0,  0, 1,   4, 1, 0,  3, 1, 0,  4));
    vecs.push_back(mk(0, 0,  0, 1,   5, 0, 1,  4, 1, 0,  4));
    vecs.push_back(mk(0, 0,  0, 1,   5, 1, 0,  4, 1, 0,  5));
    vecs.push_back(mk(0, 0,  0, 1,   6, 0, 1,  5, 1, 0,  5));
    vecs.push_back(mk(0, 0,  0, 1,   6, 0, 0,  5, 0, 1,  6));
    vecs.push_back(mk(0, 1, 20, 1,   6, 0, 0,  5, 0, 1,  6));
    vecs.push_back(mk(1, 0,  0, 1,   6, 1, 0,  5, 1, 0,  6));
    vecs.push_back(mk(0, 0,  0, 1,   7, 0, 1,  6, 1, 0,  6));
    vecs.push_back(mk(0, 0,  0, 1,   7, 1, 0,  6, 1, 0,  7));
    vecs.push_back(mk(0, 0,  0, 1,   8, 0, 1,  7, 1, 0,  7));
    vecs.push_back(mk(0, 1, 40, 1,  40, 1, 0,  7, 1, 0,  8));
    vecs.push_back(mk(0, 0,  0, 1,  41, 0, 1, 40, 1, 0,  8));
    vecs.push_back(mk(0, 0,  0, 1,  41, 1, 0, 40, 1, 0,  9));
    vecs.push_back(mk(0, 1, 10, 1,  10, 1, 0, 40, 1, 0,  9));
    vecs.push_back(mk(0, 0,  0, 1,  11, 0, 1, 10, 1, 0,  9));
    vecs.push_back(mk(0, 0,  0, 1,  11, 1, 0, 10, 1, 0, 10));
    vecs.push_back(mk(0, 0,  0, 1,  12, 0, 1, 11, 1, 0, 10));
    vecs.push_back(mk(0, 1,  5, 0,   5, 1, 0, 11, 1, 0, 10));
    vecs.push_back(mk(0, 0,  0, 1,   6, 0, 1,  5, 1, 0, 10));
    vecs.push_back(mk(0, 1, 20, 1,  20, 1, 0,  5, 1, 0, 11));
    vecs.push_back(mk(0, 0,  0, 1,  21, 0, 1, 20, 1, 0, 11));

    step();
    step();
    chk_reset("por");
    reset = 1'b1;
    step();

    foreach (vecs[i]) begin
      st0 = vecs[i].st; rdr0 = vecs[i].rd; rpc0 = vecs[i].rpc; b0.ir_ready = vecs[i].rdy;
      step();
      chk($sformatf("r%0d addr", i), 32'(b0.imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("r%0d rd", i),   32'(b0.imem_rd),   32'(vecs[i].e_rd));
      chk($sformatf("r%0d valid", i), 32'(b0.ir_valid), 32'(vecs[i].e_v));
      chk($sformatf("r%0d ir_pc", i), 32'(b0.ir_pc),    32'(vecs[i].e_ipc));
      chk($sformatf("r%0d busy", i), 32'(busy0),        32'(vecs[i].e_busy));
      chk($sformatf("r%0d halted", i), 32'(halted0),    32'(vecs[i].e_halt));
      chk($sformatf("r%0d retired", i), 32'(ret0),      32'(vecs[i].e_ret));
      if (vecs[i].e_v) chk($sformatf("r%0d data", i), b0.ir_data, word(vecs[i].e_ipc));
    end
    st0 = 1'b0; rdr0 = 1'b0; b0.ir_ready = 1'b1;

    // MEM_LAT=3: redirect in IDLE to 62, then four fetches wrapping through 63 -> 0.
    rdr3 = 1'b1; rpc3 = 6'd62;
    step();
    rdr3 = 1'b0;
    chk("idle redirect addr", 32'(b3.imem_addr), 32'd62);
    chk("idle redirect rd",   32'(b3.imem_rd),   32'd0);
    chk("idle redirect busy", 32'(busy3),        32'd0);
    st3 = 1'b1;
    step();
    st3 = 1'b0;
    chk("lat3 first addr", 32'(b3.imem_addr), 32'd62);
    exp_pc[0] = 6'd62; exp_pc[1] = 6'd63; exp_pc[2] = 6'd0; exp_pc[3] = 6'd1;
    for (int f = 0; f < 4; f++) begin
      cnt   = 0;
      guard = 0;
      while (!b3.ir_valid && guard < 20) begin
        if (b3.imem_rd) cnt++;
        step();
        guard++;
      end
      chk($sformatf("lat3 f%0d valid", f), 32'(b3.ir_valid), 32'd1);
      chk($sformatf("lat3 f%0d rd cycles", f), 32'(cnt), 32'd4);
      chk($sformatf("lat3 f%0d ir_pc", f), 32'(b3.ir_pc), 32'(exp_pc[f]));
      chk($sformatf("lat3 f%0d data", f), b3.ir_data, word(exp_pc[f]));
      if (f == 1) chk("lat3 wrap addr", 32'(b3.imem_addr), 32'd0);
      step();
    end
    chk("lat3 retired", 32'(ret3), 32'd4);
    chk("lat3 in fetch", 32'(b3.imem_rd), 32'd1);

    // Asynchronous reset mid-FETCH, between clock edges.
    #3;
    reset = 1'b0;
    #1;
    chk_reset("async");
    step();
    reset = 1'b1;
    st3 = 1'b1;
    step();
    st3 = 1'b0;
    chk("post reset addr", 32'(b3.imem_addr), 32'd0);
    chk("post reset rd",   32'(b3.imem_rd),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch controller that owns the program counter and sequences reads of the instruction memory (6-bit word address, 32-bit instruction) for the Harvard core. It replaces the free-running up-counter as the instruction address source. It adds start/halt control, branch redirect, a configurable memory read latency, and a valid/ready handoff of each fetched instruction to decode.

## Interface
- ADDR_W, 6, instruction memory word-address width
- INSTR_W, 32, instruction width
- MEM_LAT, 0, cycles between address presentation and data sample (0..3; 0 = combinational memory, sampled in the same cycle)
- RESET_PC, 0, PC value after reset
- HALT_OP, 6'b111111, opcode in instruction bits [31:26] that halts fetch

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin or resume fetching (level, sampled in IDLE/HALT)
- redirect  in  1  one-cycle request to load redirect_pc
- redirect_pc  in  ADDR_W  branch/jump target
- imem_addr  out  ADDR_W  instruction memory address (= PC register)
- imem_rd  out  1  read strobe
- imem_data  in  INSTR_W  instruction memory read data
- ir_valid  out  1  ir_data/ir_pc hold a fetched instruction
- ir_ready  in  1  decode accepts when ir_valid & ir_ready
- ir_data  out  INSTR_W  fetched instruction
- ir_pc  out  ADDR_W  address ir_data was fetched from
- busy  out  1  state is FETCH or HOLD
- halted  out  1  state is HALT
- retired  out  16  count of accepted instructions, saturating at 16'hFFFF

## Operation
- States: IDLE, FETCH, HOLD, HALT. A latency counter `lat` (2 bits) is used only in FETCH.
- IDLE: outputs quiescent. On start, lat←0 and the state goes to FETCH.
- FETCH: imem_rd=1 and imem_addr=pc.
  - If lat==MEM_LAT: ir_data←imem_data, ir_pc←pc, pc←pc+1 modulo 2^ADDR_W (63 wraps to 0), then go to HOLD.
  - Otherwise lat←lat+1.
- HOLD: ir_valid=1 and imem_rd=0. On ir_ready, retired increments.
  - If ir_data[31:26]==HALT_OP, go to HALT.
  - Otherwise lat←0 and go to FETCH.
  - Without ir_ready, ir_data and ir_pc stay stable.
- HALT: imem_rd=0 and ir_valid=0. On start, lat←0 and go to FETCH from the current pc (the address after the halt instruction).
- Redirect priority is redirect > halt decode > normal flow.
  - IDLE: pc←redirect_pc; stay in IDLE.
  - FETCH: abort the read, pc←redirect_pc, lat←0, stay in FETCH.
  - HOLD: pc←redirect_pc, lat←0, go to FETCH, and ir_valid drops next cycle.
    - If ir_ready is also high, the transfer counts as accepted and retired increments.
    - A halt opcode in that transfer is ignored.
  - HALT: redirect is ignored.
- retired saturates and never wraps. It clears only on reset.

## Timing
- Reset (asynchronous on assertion, released synchronously by the clk domain):
  - state=IDLE, pc=RESET_PC, lat=0
  - imem_addr=RESET_PC, imem_rd=0
  - ir_valid=0, ir_data=0, ir_pc=0
  - busy=0, halted=0, retired=0
- Reset mid-FETCH or mid-HOLD discards the instruction in flight immediately.
- All outputs are registered or decoded from state only. There is no combinational path from ir_ready or redirect to any output.
- Latency:
  - start high at edge N puts the state in FETCH from N+1.
  - The first ir_valid rises at edge N+2+MEM_LAT.
- Steady-state throughput with ir_ready held high is one instruction per MEM_LAT+2 cycles.
- A redirect sampled at edge R puts imem_addr=redirect_pc from R+1. The target instruction becomes valid at R+2+MEM_LAT.
- When pc wraps past 63, ir_pc=63 and the next imem_addr=0.

## Test plan
- Reset/sequential, MEM_LAT=0, memory word k = {6'h00, 26'(k)}, ir_ready=1, start pulsed:
  - ir_pc steps 0,1,2,… with ir_valid every 2nd cycle.
  - ir_data[25:0] equals ir_pc.
  - retired reaches 10 after 10 handshakes.
- Back-pressure: hold ir_ready=0 for 5 cycles in HOLD at pc 3.
  - ir_valid stays 1, ir_data and ir_pc are stable (ir_pc=3), imem_rd=0, retired unchanged.
  - Releasing ir_ready gives fetch of pc 4.
- Halt: word 5 = {HALT_OP, 26'h0}.
  - Accepting it sets halted=1 and busy=0, with no further imem_rd.
  - start then resumes with imem_addr=6.
- Redirect: redirect=1 with redirect_pc=40 while in HOLD for pc 7 with ir_ready=1.
  - retired increments.
  - The next imem_addr is 40 and the next ir_pc is 40.
  - Redirect in FETCH gives no ir_valid for the aborted address.
- Latency/wrap, MEM_LAT=3, redirect_pc=62:
  - imem_rd is high for 4 cycles per fetch.
  - ir_pc sequence is 62, 63, 0, 1.
- Async reset asserted mid-FETCH, between edges:
  - all outputs reach reset values without waiting for a clock edge.
  - After release and start, the first imem_addr is RESET_PC.
